uds_ctrl: RTL and testbench

Control-only sequencer for the up/down-sample engine. Accepts one job descriptor at a time, pulls input row-tiles from the upstream feature-map buffer with a valid/ready handshake, and drives the engine's `idata_valid`, `active`, `function_mode` and `scale_factor` inputs in the load/compute pattern each mode needs. The tile data bus goes straight from the buffer to the engine; this block only gates it through `in_ready`.

---
 rtl/uds_ctrl.sv | 152 +++++++++++++++
 tb/tb_uds_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uds_ctrl.sv
// Load/compute sequencer for the up/down-sample engine: one job descriptor at a time.
// Optional stall counter on perf_stall is built when UDS_CTRL_PERF_EN is defined.
module uds_ctrl #(
    parameter int CNT_W     = 8,
    parameter int DRAIN_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_mode,
    input  logic [1:0]       cfg_scale,
    input  logic [CNT_W-1:0] cfg_tiles,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             out_ready,
    output logic             uds_idata_valid,
    output logic             uds_active,
    output logic [1:0]       uds_function_mode,
    output logic [1:0]       uds_scale_factor,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [15:0]      perf_stall
);

    typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, HOLD, DRAIN, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] rem;
    logic [1:0]       ld_cnt;
    logic [1:0]       need;
    logic [15:0]      drain_cnt;
    logic [1:0]       mode_q;
    logic [1:0]       scale_q;
    logic             err_q;

    logic             cfg_legal;
    logic [1:0]       first_need;
    logic             accept;
    logic             handshake;

    always_comb begin
        cfg_legal = 1'b0;
        if (cfg_mode[1])
            cfg_legal = (cfg_tiles >= CNT_W'(2));
        else if (cfg_scale == 2'd0)
            cfg_legal = !cfg_tiles[0] && (cfg_tiles >= CNT_W'(2));
        else if (cfg_scale == 2'd1)
            cfg_legal = cfg_tiles[0] && (cfg_tiles >= CNT_W'(3));
    end

    assign first_need = (!cfg_mode[1] && cfg_scale == 2'd1) ? 2'd3 : 2'd2;
    assign accept     = cfg_valid && (state == IDLE);
    assign handshake  = in_valid && in_ready;

    assign cfg_ready         = (state == IDLE);
    assign busy              = (state != IDLE);
    assign done              = (state == DONE);
    assign in_ready          = (state == LOAD);
    assign uds_idata_valid   = handshake;
    assign uds_active        = (state == COMPUTE) && out_ready;
    assign uds_function_mode = mode_q;
    assign uds_scale_factor  = scale_q;
    assign err               = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rem       <= '0;
            ld_cnt    <= 2'd0;
            need      <= 2'd0;
            drain_cnt <= 16'd0;
            mode_q    <= 2'd0;
            scale_q   <= 2'd0;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (cfg_legal) begin
                            mode_q  <= cfg_mode;
                            scale_q <= cfg_scale;
                            rem     <= cfg_tiles;
                            ld_cnt  <= 2'd0;
                            need    <= first_need;
                            state   <= LOAD;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (handshake) begin
                        rem <= rem - CNT_W'(1);
                        if (ld_cnt + 2'd1 == need) begin
                            ld_cnt <= 2'd0;
                            state  <= COMPUTE;
                        end else begin
                            ld_cnt <= ld_cnt + 2'd1;
                        end
                    end
                end
                COMPUTE: begin
                    // Later computes reuse overlap rows, so the per-compute load shrinks.
                    if (out_ready) begin
                        need  <= mode_q[1] ? 2'd1 : 2'd2;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (rem >= CNT_W'(need)) begin
                        state <= LOAD;
                    end else if (DRAIN_CYC == 0) begin
                        state <= DONE;
                    end else begin
                        drain_cnt <= 16'(DRAIN_CYC - 1);
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == 16'd0)
                        state <= DONE;
                    else
                        drain_cnt <= drain_cnt - 16'd1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef UDS_CTRL_PERF_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= 16'd0;
        else if (accept)
            stall_cnt <= 16'd0;
        else if (((state == LOAD && !in_valid) || (state == COMPUTE && !out_ready))
                 && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end

    assign perf_stall = stall_cnt;
`else
    assign perf_stall = 16'd0;
`endif

endmodule

// File: tb/tb_uds_ctrl.sv
// Directed self-checking bench for uds_ctrl; cycle numbers count from the descriptor cycle c0.
module tb_uds_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_mode = 2'd0;
    logic [1:0]  cfg_scale = 2'd0;
    logic [7:0]  cfg_tiles = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        out_ready = 1'b1;
    logic        uds_idata_valid;
    logic        uds_active;
    logic [1:0]  uds_function_mode;
    logic [1:0]  uds_scale_factor;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] perf_stall;

    int n_assert = 0;
    int n_fail   = 0;

    int n_act, act1, act2, n_iv, done_c, hold_bad, perf_done;
    int exp_perf;

    uds_ctrl #(.CNT_W(8), .DRAIN_CYC(2)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cfg_valid         (cfg_valid),
        .cfg_ready         (cfg_ready),
        .cfg_mode          (cfg_mode),
        .cfg_scale         (cfg_scale),
        .cfg_tiles         (cfg_tiles),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .out_ready         (out_ready),
        .uds_idata_valid   (uds_idata_valid),
        .uds_active        (uds_active),
        .uds_function_mode (uds_function_mode),
        .uds_scale_factor  (uds_scale_factor),
        .busy              (busy),
        .done              (done),
        .err               (err),
        .perf_stall        (perf_stall)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Issues one descriptor and follows the job to done, holding out_ready low
    // for lo_len cycles starting at cycle lo_start.
    task automatic applyStimulus(input logic [1:0] m, input logic [1:0] s, input logic [7:0] t,
                                 input int lo_start, input int lo_len,
                                 output int o_act, output int o_act1, output int o_act2,
                                 output int o_iv, output int o_done, output int o_hold_bad,
                                 output int o_perf);
        int prev_act;
        o_act = 0; o_act1 = -1; o_act2 = -1; o_iv = 0; o_done = -1;
        o_hold_bad = 0; o_perf = -1; prev_act = 0;
        @(posedge clk); #1;
        cfg_valid = 1'b1; cfg_mode = m; cfg_scale = s; cfg_tiles = t;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        for (int k = 1; k <= 100 && o_done < 0; k++) begin
            out_ready = !(k >= lo_start && k < lo_start + lo_len);
            @(negedge clk);
            if (prev_act != 0 && in_ready) o_hold_bad++;
            prev_act = int'(uds_active);
            if (uds_active) begin
                o_act++;
                if (o_act1 < 0) o_act1 = k;
                else if (o_act2 < 0) o_act2 = k;
            end
            if (uds_idata_valid) o_iv++;
            if (done) begin
                o_done = k;
                o_perf = int'(perf_stall);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
    endtask

    task automatic applyIllegal(input string tag, input logic [1:0] m, input logic [1:0] s,
                                input logic [7:0] t, input logic [1:0] exp_mode,
                                input logic [1:0] exp_scale);
        @(posedge clk); #1;
        cfg_valid = 1'b1; cfg_mode = m; cfg_scale = s; cfg_tiles = t;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_err"}, 32'(err), 32'd1);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_mode"}, 32'(uds_function_mode), 32'(exp_mode));
        checkOutput({tag, "_scale"}, 32'(uds_scale_factor), 32'(exp_scale));
        @(negedge clk);
        checkOutput({tag, "_err_once"}, 32'(err), 32'd0);
        checkOutput({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
`ifdef UDS_CTRL_PERF_EN
        exp_perf = 5;
`else
        exp_perf = 0;
`endif
        // Reset state, with in_valid high to show IDLE does not accept tiles.
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_idata_valid", 32'(uds_idata_valid), 32'd0);
        checkOutput("rst_active", 32'(uds_active), 32'd0);
        checkOutput("rst_mode", 32'(uds_function_mode), 32'd0);
        checkOutput("rst_scale", 32'(uds_scale_factor), 32'd0);
        checkOutput("rst_perf", 32'(perf_stall), 32'd0);
        rst_n = 1'b1;

        $display("[TB] minimum-latency DS2x2, 2 tiles");
        applyStimulus(2'b00, 2'd0, 8'd2, 0, 0, n_act, act1, act2, n_iv, done_c, hold_bad, perf_done);
        checkOutput("min_n_active", 32'(n_act), 32'd1);
        checkOutput("min_active_cyc", 32'(act1), 32'd3);
        checkOutput("min_done_cyc", 32'(done_c), 32'd7);
        checkOutput("min_n_idata", 32'(n_iv), 32'd2);
        @(negedge clk);
        checkOutput("min_idle_after", 32'(cfg_ready), 32'd1);

        $display("[TB] DS2x2 max, 4 tiles");
        applyStimulus(2'b00, 2'd0, 8'd4, 0, 0, n_act, act1, act2, n_iv, done_c, hold_bad, perf_done);
        checkOutput("ds2_n_active", 32'(n_act), 32'd2);
        checkOutput("ds2_active1_cyc", 32'(act1), 32'd3);
        checkOutput("ds2_active2_cyc", 32'(act2), 32'd7);
        checkOutput("ds2_done_cyc", 32'(done_c), 32'd11);
        checkOutput("ds2_n_idata", 32'(n_iv), 32'd4);
        checkOutput("ds2_perf", 32'(perf_done), 32'd0);

        $display("[TB] DS3x3 avg, 5 tiles");
        applyStimulus(2'b01, 2'd1, 8'd5, 0, 0, n_act, act1, act2, n_iv, done_c, hold_bad, perf_done);
        checkOutput("ds3_n_active", 32'(n_act), 32'd2);
        checkOutput("ds3_active1_cyc", 32'(act1), 32'd4);
        checkOutput("ds3_active2_cyc", 32'(act2), 32'd8);
        checkOutput("ds3_done_cyc", 32'(done_c), 32'd12);
        checkOutput("ds3_n_idata", 32'(n_iv), 32'd5);
        checkOutput("ds3_mode", 32'(uds_function_mode), 32'd1);
        checkOutput("ds3_scale", 32'(uds_scale_factor), 32'd1);

        $display("[TB] upsample avg, 3 tiles");
        applyStimulus(2'b11, 2'd0, 8'd3, 0, 0, n_act, act1, act2, n_iv, done_c, hold_bad, perf_done);
        checkOutput("us_n_active", 32'(n_act), 32'd2);
        checkOutput("us_active1_cyc", 32'(act1), 32'd3);
        checkOutput("us_active2_cyc", 32'(act2), 32'd6);
        checkOutput("us_done_cyc", 32'(done_c), 32'd10);
        checkOutput("us_n_idata", 32'(n_iv), 32'd3);
        checkOutput("us_hold_in_ready", 32'(hold_bad), 32'd0);
        checkOutput("us_mode", 32'(uds_function_mode), 32'd3);

        $display("[TB] illegal descriptors");
        applyIllegal("ill_ds2_odd", 2'b00, 2'd0, 8'd3, 2'b11, 2'd0);
        applyIllegal("ill_ds_scale2", 2'b01, 2'd2, 8'd4, 2'b11, 2'd0);
        applyIllegal("ill_us_one", 2'b10, 2'd0, 8'd1, 2'b11, 2'd0);

        $display("[TB] out_ready low 5 cycles in COMPUTE");
        applyStimulus(2'b00, 2'd0, 8'd2, 3, 5, n_act, act1, act2, n_iv, done_c, hold_bad, perf_done);
        checkOutput("stall_n_active", 32'(n_act), 32'd1);
        checkOutput("stall_active_cyc", 32'(act1), 32'd8);
        checkOutput("stall_done_cyc", 32'(done_c), 32'd12);
        checkOutput("stall_n_idata", 32'(n_iv), 32'd2);
        checkOutput("stall_perf", 32'(perf_done), 32'(exp_perf));

        $display("[TB] reset in the middle of LOAD");
        @(posedge clk); #1;
        cfg_valid = 1'b1; cfg_mode = 2'b10; cfg_scale = 2'd0; cfg_tiles = 8'd4; in_valid = 1'b1;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        @(negedge clk);
        checkOutput("mid_in_ready", 32'(in_ready), 32'd1);
        checkOutput("mid_mode", 32'(uds_function_mode), 32'd2);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_cfg_ready", 32'(cfg_ready), 32'd1);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("mid_rst_idata", 32'(uds_idata_valid), 32'd0);
        checkOutput("mid_rst_active", 32'(uds_active), 32'd0);
        checkOutput("mid_rst_mode", 32'(uds_function_mode), 32'd0);
        checkOutput("mid_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(2'b00, 2'd0, 8'd2, 0, 0, n_act, act1, act2, n_iv, done_c, hold_bad, perf_done);
        checkOutput("post_rst_n_active", 32'(n_act), 32'd1);
        checkOutput("post_rst_active_cyc", 32'(act1), 32'd3);
        checkOutput("post_rst_done_cyc", 32'(done_c), 32'd7);
        checkOutput("post_rst_n_idata", 32'(n_iv), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
